// File: rtl/rob_multi_commit_pkg.sv
// rob_multi_commit_pkg
//   Shared constants for the multi-commit reorder buffer and its helpers.
//   Holds the default entry-index, register-index and PC widths together with
//   the slot counts. It also provides the depth derivation used by every user
//   of the ROB index width.
//   No ports (package).
package rob_multi_commit_pkg;

  localparam int ROB_SEL_DEF      = 6;
  localparam int DP_WIDTH_DEF     = 2;
  localparam int COMMIT_WIDTH_DEF = 2;
  localparam int EX_PORTS_DEF     = 4;
  localparam int PC_LEN_DEF       = 32;
  localparam int REG_SEL_DEF      = 5;

  // Number of ROB entries addressed by an index of 'sel' bits.
  function automatic int rob_num(input int sel);
    return 32'sd1 << sel;
  endfunction

endpackage

// File: rtl/rob_multi_commit_if.sv
// rob_multi_commit_if
//   Bundles the dispatch, completion and commit signals of the reorder buffer.
//   Modport master : pipeline side; it drives dispatch and completion and
//                    receives the commit results.
//   Modport slave  : ROB side.
//   Signals:
//     dp_valid_i/dp_pc_i/dp_dstvalid_i/dp_dst_i : per-slot dispatch request
//     dp_ready_o, dp_addr_o                     : dispatch acceptance, entry per slot
//     ex_finish_i, ex_addr_i                    : completion strobe/entry per port
//     commit_ptr_o, comnum_o, arfwe_o,
//     dst_arf_o, commit_pc_o                    : commit slots toward the ARF
//     empty_o, full_o                           : occupancy flags
//   Define ROB_EXCEPTION_EN to add ex_exc_i, exc_o and exc_pc_o.
interface rob_multi_commit_if
  import rob_multi_commit_pkg::*;
#(
  parameter int ROB_SEL      = ROB_SEL_DEF,
  parameter int DP_WIDTH     = DP_WIDTH_DEF,
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  parameter int EX_PORTS     = EX_PORTS_DEF,
  parameter int PC_LEN       = PC_LEN_DEF,
  parameter int REG_SEL      = REG_SEL_DEF
);
  localparam int CN_W = $clog2(COMMIT_WIDTH + 1);

  logic [DP_WIDTH-1:0]              dp_valid_i;
  logic [DP_WIDTH*PC_LEN-1:0]       dp_pc_i;
  logic [DP_WIDTH-1:0]              dp_dstvalid_i;
  logic [DP_WIDTH*REG_SEL-1:0]      dp_dst_i;
  logic                             dp_ready_o;
  logic [DP_WIDTH*ROB_SEL-1:0]      dp_addr_o;
  logic [EX_PORTS-1:0]              ex_finish_i;
  logic [EX_PORTS*ROB_SEL-1:0]      ex_addr_i;
  logic [ROB_SEL-1:0]               commit_ptr_o;
  logic [CN_W-1:0]                  comnum_o;
  logic [COMMIT_WIDTH-1:0]          arfwe_o;
  logic [COMMIT_WIDTH*REG_SEL-1:0]  dst_arf_o;
  logic [COMMIT_WIDTH*PC_LEN-1:0]   commit_pc_o;
  logic                             empty_o;
  logic                             full_o;
`ifdef ROB_EXCEPTION_EN
  logic [EX_PORTS-1:0]              ex_exc_i;
  logic                             exc_o;
  logic [PC_LEN-1:0]                exc_pc_o;

  modport master (
    output dp_valid_i, dp_pc_i, dp_dstvalid_i, dp_dst_i, ex_finish_i, ex_addr_i, ex_exc_i,
    input  dp_ready_o, dp_addr_o, commit_ptr_o, comnum_o, arfwe_o, dst_arf_o,
           commit_pc_o, empty_o, full_o, exc_o, exc_pc_o
  );
  modport slave (
    input  dp_valid_i, dp_pc_i, dp_dstvalid_i, dp_dst_i, ex_finish_i, ex_addr_i, ex_exc_i,
    output dp_ready_o, dp_addr_o, commit_ptr_o, comnum_o, arfwe_o, dst_arf_o,
           commit_pc_o, empty_o, full_o, exc_o, exc_pc_o
  );
`else
  modport master (
    output dp_valid_i, dp_pc_i, dp_dstvalid_i, dp_dst_i, ex_finish_i, ex_addr_i,
    input  dp_ready_o, dp_addr_o, commit_ptr_o, comnum_o, arfwe_o, dst_arf_o,
           commit_pc_o, empty_o, full_o
  );
  modport slave (
    input  dp_valid_i, dp_pc_i, dp_dstvalid_i, dp_dst_i, ex_finish_i, ex_addr_i,
    output dp_ready_o, dp_addr_o, commit_ptr_o, comnum_o, arfwe_o, dst_arf_o,
           commit_pc_o, empty_o, full_o
  );
`endif
endinterface

// File: rtl/rob_commit_sel.sv
// rob_commit_sel
//   Prefix-ready chain for in-order multi-retire. A slot is ready only when it
//   and every lower slot are retirable. The module also counts the ready slots.
//   Ports:
//     slot_ok  : per-slot "this entry could retire" (valid, finished, in range)
//     slot_rdy : per-slot retire decision (prefix AND of slot_ok)
//     rdy_num  : number of ready slots
module rob_commit_sel #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]             slot_ok,
  output logic [WIDTH-1:0]             slot_rdy,
  output logic [$clog2(WIDTH+1)-1:0]   rdy_num
);
  localparam int CN_W = $clog2(WIDTH + 1);

  logic run_s;

  // Walk the slots in order; the first non-retirable slot blocks all above it.
  always_comb begin
    run_s    = 1'b1;
    slot_rdy = '0;
    rdy_num  = '0;
    for (int j = 0; j < WIDTH; j++) begin
      run_s       = run_s & slot_ok[j];
      slot_rdy[j] = run_s;
      rdy_num     = rdy_num + CN_W'(run_s);
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit
//   Reorder buffer with multi-slot dispatch and multi-slot in-order commit.
//   The ROB owns the head, tail and count. It allocates up to DP_WIDTH entries
//   per cycle, marks entries finished from EX_PORTS completion ports, and
//   retires up to COMMIT_WIDTH consecutive finished entries per cycle.
//   Ports:
//     clk_i   : clock, rising edge
//     reset_i : synchronous, active-low reset
//     bus     : rob_multi_commit_if.slave (dispatch / completion / commit)
//   Optional: define ROB_EXCEPTION_EN for per-entry exception tracking. An
//   excepting entry at head retires alone with arfwe=0 and raises exc_o. On the
//   following edge, the whole buffer is flushed.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int ROB_SEL      = ROB_SEL_DEF,
  parameter int DP_WIDTH     = DP_WIDTH_DEF,
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  parameter int EX_PORTS     = EX_PORTS_DEF,
  parameter int PC_LEN       = PC_LEN_DEF,
  parameter int REG_SEL      = REG_SEL_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  rob_multi_commit_if.slave  bus
);
  localparam int ROB_NUM = rob_num(ROB_SEL);
  localparam int CNT_W   = ROB_SEL + 1;
  localparam int CN_W    = $clog2(COMMIT_WIDTH + 1);

  logic [ROB_NUM-1:0]     valid_r, finish_r, dstv_mem_r;
  logic [ROB_NUM-1:0]     valid_nxt_s, finish_nxt_s;
  logic [PC_LEN-1:0]      pc_mem_r  [ROB_NUM];
  logic [REG_SEL-1:0]     dst_mem_r [ROB_NUM];
  logic [ROB_SEL-1:0]     head_r, tail_r;
  logic [CNT_W-1:0]       count_r;

  logic                   dp_ready_s;
  logic [CNT_W-1:0]       ndp_s;
  logic [ROB_SEL-1:0]     dp_addr_s [DP_WIDTH];
  logic [ROB_SEL-1:0]     cm_addr_s [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] slot_ok_s, slot_rdy_s;
  logic [CN_W-1:0]        sel_num_s, comnum_s;
  logic                   flush_s;

`ifdef ROB_EXCEPTION_EN
  logic [ROB_NUM-1:0]     exc_r, exc_nxt_s;
  logic                   exc_head_s;
`endif

  // Room is judged on the registered count, so entries freed this cycle are
  // only reusable next cycle.
  assign dp_ready_s     = (CNT_W'(ROB_NUM) - count_r) >= CNT_W'(DP_WIDTH);
  assign bus.dp_ready_o = dp_ready_s;
  assign bus.empty_o    = (count_r == CNT_W'(0));
  assign bus.full_o     = (count_r == CNT_W'(ROB_NUM));
  assign bus.commit_ptr_o = head_r;

  for (genvar k = 0; k < DP_WIDTH; k++) begin : g_dp
    assign dp_addr_s[k] = tail_r + ROB_SEL'(k);
    assign bus.dp_addr_o[k*ROB_SEL +: ROB_SEL] = dp_addr_s[k];
  end

  for (genvar j = 0; j < COMMIT_WIDTH; j++) begin : g_cm
    assign cm_addr_s[j] = head_r + ROB_SEL'(j);
`ifdef ROB_EXCEPTION_EN
    // An excepting entry never retires through the normal chain.
    assign slot_ok_s[j] = valid_r[cm_addr_s[j]] & finish_r[cm_addr_s[j]] &
                          ~exc_r[cm_addr_s[j]] & (count_r > CNT_W'(j));
`else
    assign slot_ok_s[j] = valid_r[cm_addr_s[j]] & finish_r[cm_addr_s[j]] &
                          (count_r > CNT_W'(j));
`endif
    assign bus.arfwe_o[j] = slot_rdy_s[j] & dstv_mem_r[cm_addr_s[j]];
    assign bus.dst_arf_o[j*REG_SEL +: REG_SEL]  = dst_mem_r[cm_addr_s[j]];
    assign bus.commit_pc_o[j*PC_LEN +: PC_LEN]  = pc_mem_r[cm_addr_s[j]];
  end

  rob_commit_sel #(
    .WIDTH (COMMIT_WIDTH)
  ) u_commit_sel (
    .slot_ok  (slot_ok_s),
    .slot_rdy (slot_rdy_s),
    .rdy_num  (sel_num_s)
  );

`ifdef ROB_EXCEPTION_EN
  assign exc_head_s   = (count_r != CNT_W'(0)) & valid_r[head_r] & finish_r[head_r] & exc_r[head_r];
  assign comnum_s     = exc_head_s ? CN_W'(1) : sel_num_s;
  assign flush_s      = exc_head_s;
  assign bus.exc_o    = exc_head_s;
  assign bus.exc_pc_o = pc_mem_r[head_r];
`else
  assign comnum_s     = sel_num_s;
  assign flush_s      = 1'b0;
`endif
  assign bus.comnum_o = comnum_s;

  // Number of slots actually allocated this cycle (zero when not ready).
  always_comb begin
    ndp_s = '0;
    for (int k = 0; k < DP_WIDTH; k++) begin
      ndp_s = ndp_s + CNT_W'(bus.dp_valid_i[k] & dp_ready_s);
    end
  end

  // Next valid/finish flags. Completion looks at the current valid bits, so
  // strobes to free or just-allocated entries fall away. Commit then clears the
  // retiring entries, and dispatch claims free entries last.
  always_comb begin
    valid_nxt_s  = valid_r;
    finish_nxt_s = finish_r;
`ifdef ROB_EXCEPTION_EN
    exc_nxt_s    = exc_r;
`endif
    for (int p = 0; p < EX_PORTS; p++) begin
      finish_nxt_s[bus.ex_addr_i[p*ROB_SEL +: ROB_SEL]] =
        finish_nxt_s[bus.ex_addr_i[p*ROB_SEL +: ROB_SEL]] |
        (bus.ex_finish_i[p] & valid_r[bus.ex_addr_i[p*ROB_SEL +: ROB_SEL]]);
`ifdef ROB_EXCEPTION_EN
      exc_nxt_s[bus.ex_addr_i[p*ROB_SEL +: ROB_SEL]] =
        exc_nxt_s[bus.ex_addr_i[p*ROB_SEL +: ROB_SEL]] |
        (bus.ex_finish_i[p] & bus.ex_exc_i[p] & valid_r[bus.ex_addr_i[p*ROB_SEL +: ROB_SEL]]);
`endif
    end
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      valid_nxt_s[cm_addr_s[j]]  = valid_nxt_s[cm_addr_s[j]]  & ~slot_rdy_s[j];
      finish_nxt_s[cm_addr_s[j]] = finish_nxt_s[cm_addr_s[j]] & ~slot_rdy_s[j];
    end
    for (int k = 0; k < DP_WIDTH; k++) begin
      valid_nxt_s[dp_addr_s[k]]  = valid_nxt_s[dp_addr_s[k]] | (dp_ready_s & bus.dp_valid_i[k]);
      finish_nxt_s[dp_addr_s[k]] = finish_nxt_s[dp_addr_s[k]] & ~(dp_ready_s & bus.dp_valid_i[k]);
`ifdef ROB_EXCEPTION_EN
      exc_nxt_s[dp_addr_s[k]]    = exc_nxt_s[dp_addr_s[k]] & ~(dp_ready_s & bus.dp_valid_i[k]);
`endif
    end
  end

  // Control state: pointers, count and per-entry flags; reset and exception
  // flush both return to an empty buffer at index 0.
  always_ff @(posedge clk_i) begin
    if (!reset_i || flush_s) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      valid_r  <= '0;
      finish_r <= '0;
`ifdef ROB_EXCEPTION_EN
      exc_r    <= '0;
`endif
    end else begin
      head_r   <= head_r + ROB_SEL'(comnum_s);
      tail_r   <= tail_r + ndp_s[ROB_SEL-1:0];
      count_r  <= count_r + ndp_s - CNT_W'(comnum_s);
      valid_r  <= valid_nxt_s;
      finish_r <= finish_nxt_s;
`ifdef ROB_EXCEPTION_EN
      exc_r    <= exc_nxt_s;
`endif
    end
  end

  // Payload capture on allocation; payload is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DP_WIDTH; k++) begin
      if (dp_ready_s && bus.dp_valid_i[k]) begin
        pc_mem_r[dp_addr_s[k]]   <= bus.dp_pc_i[k*PC_LEN +: PC_LEN];
        dst_mem_r[dp_addr_s[k]]  <= bus.dp_dst_i[k*REG_SEL +: REG_SEL];
        dstv_mem_r[dp_addr_s[k]] <= bus.dp_dstvalid_i[k];
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit
//   Self-checking bench for rob_multi_commit. The reference is a queue of
//   in-flight instructions in program order plus a head index. Each cycle, the
//   expected outputs are derived from that queue and compared with the DUT.
//   Directed scenarios pin a few literal values; randomized traffic follows.
module tb_rob_multi_commit;
  import rob_multi_commit_pkg::*;

  localparam int RSEL = 6, N = 64, DP = 2, CW = 2, EXP = 4, PCL = 32, RS = 5;

  typedef struct {
    int             idx;
    logic [PCL-1:0] pc;
    logic [RS-1:0]  dst;
    bit             dstv;
    bit             fin;
    bit             exc;
  } ent_t;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rob_multi_commit_if #(.ROB_SEL(RSEL), .DP_WIDTH(DP), .COMMIT_WIDTH(CW),
                        .EX_PORTS(EXP), .PC_LEN(PCL), .REG_SEL(RS)) bus ();

  rob_multi_commit #(.ROB_SEL(RSEL), .DP_WIDTH(DP), .COMMIT_WIDTH(CW),
                     .EX_PORTS(EXP), .PC_LEN(PCL), .REG_SEL(RS)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  ent_t mq[$];
  int   mh = 0;
  bit   known = 0;
  int   n_cmp = 0, n_bad = 0;
  int   seen_commits = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // In-order retire count: consecutive finished, non-excepting entries at the front.
  function automatic int model_retire();
    int n = 0;
    while (n < CW && n < mq.size() && mq[n].fin && !mq[n].exc) n++;
    return n;
  endfunction

  function automatic bit model_exc_head();
    return mq.size() > 0 && mq[0].fin && mq[0].exc;
  endfunction

  task automatic compare();
    int n, sz;
    bit excp;
    logic [CW-1:0]     e_we;
    logic [CW*RS-1:0]  e_dst, a_dst;
    logic [CW*PCL-1:0] e_pc, a_pc;
    logic [DP*RSEL-1:0] e_addr;
    if (!known) return;
    sz = mq.size();
    n = model_retire();
    excp = model_exc_head();
    e_we = '0; e_dst = '0; a_dst = '0; e_pc = '0; a_pc = '0;
    for (int j = 0; j < n; j++) begin
      e_we[j] = mq[j].dstv;
      e_dst[j*RS +: RS] = mq[j].dst;
      a_dst[j*RS +: RS] = bus.dst_arf_o[j*RS +: RS];
      e_pc[j*PCL +: PCL] = mq[j].pc;
      a_pc[j*PCL +: PCL] = bus.commit_pc_o[j*PCL +: PCL];
    end
    for (int k = 0; k < DP; k++) e_addr[k*RSEL +: RSEL] = RSEL'((mh + sz + k) % N);
    chk("commit_ptr", bus.commit_ptr_o, mh);
    chk("comnum", bus.comnum_o, excp ? 1 : n);
    chk("arfwe", bus.arfwe_o, e_we);
    chk("dst_arf", a_dst, e_dst);
    chk("commit_pc", a_pc, e_pc);
    chk("dp_addr", bus.dp_addr_o, e_addr);
    chk("dp_ready", bus.dp_ready_o, (N - sz) >= DP);
    chk("empty", bus.empty_o, sz == 0);
    chk("full", bus.full_o, sz == N);
`ifdef ROB_EXCEPTION_EN
    chk("exc", bus.exc_o, excp);
    if (excp) chk("exc_pc", bus.exc_pc_o, mq[0].pc);
`endif
    seen_commits += int'(bus.comnum_o);
  endtask

  // Apply one clock edge to the model using the inputs that were presented.
  task automatic model_edge();
    int sz0, tail0, n;
    bit rdy, excp;
    ent_t e;
    if (!reset_i) begin
      mq.delete(); mh = 0; known = 1;
      return;
    end
    if (!known) return;
    sz0 = mq.size();
    rdy = (N - sz0) >= DP;
    tail0 = (mh + sz0) % N;
    n = model_retire();
    excp = model_exc_head();
    for (int p = 0; p < EXP; p++) begin
      if (bus.ex_finish_i[p]) begin
        foreach (mq[i]) begin
          if (mq[i].idx == int'(bus.ex_addr_i[p*RSEL +: RSEL])) begin
            mq[i].fin = 1;
`ifdef ROB_EXCEPTION_EN
            if (bus.ex_exc_i[p]) mq[i].exc = 1;
`endif
          end
        end
      end
    end
    if (excp) begin
      mq.delete(); mh = 0;
      return;
    end
    for (int j = 0; j < n; j++) void'(mq.pop_front());
    mh = (mh + n) % N;
    if (rdy) begin
      for (int k = 0; k < DP; k++) begin
        if (bus.dp_valid_i[k]) begin
          e.idx = (tail0 + k) % N;
          e.pc = bus.dp_pc_i[k*PCL +: PCL];
          e.dst = bus.dp_dst_i[k*RS +: RS];
          e.dstv = bus.dp_dstvalid_i[k];
          e.fin = 0; e.exc = 0;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic cycle();
    #1 compare();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    bus.dp_valid_i = '0; bus.dp_pc_i = '0; bus.dp_dstvalid_i = '0; bus.dp_dst_i = '0;
    bus.ex_finish_i = '0; bus.ex_addr_i = '0;
`ifdef ROB_EXCEPTION_EN
    bus.ex_exc_i = '0;
`endif
  endtask

  task automatic set_dp(input int k, input logic [PCL-1:0] pc, input logic [RS-1:0] dst, input bit dv);
    bus.dp_valid_i[k] = 1'b1;
    bus.dp_pc_i[k*PCL +: PCL] = pc;
    bus.dp_dst_i[k*RS +: RS] = dst;
    bus.dp_dstvalid_i[k] = dv;
  endtask

  task automatic set_ex(input int p, input int addr);
    bus.ex_finish_i[p] = 1'b1;
    bus.ex_addr_i[p*RSEL +: RSEL] = RSEL'(addr);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    idle_inputs();
    while (!bus.empty_o && t < budget) begin
      cycle();
      t++;
    end
    chk("drain_done", bus.empty_o, 1'b1);
  endtask

  initial begin
    int mode, dpp, cpp, nv, sz;
    idle_inputs();
    reset_i = 1'b0;
    @(negedge clk_i);
    cycle();
    cycle();
    reset_i = 1'b1;

    // Reset then idle
    #1;
    chk("t1_empty", bus.empty_o, 1'b1);
    chk("t1_comnum", bus.comnum_o, 2'd0);
    chk("t1_ptr", bus.commit_ptr_o, 6'd0);
    chk("t1_ready", bus.dp_ready_o, 1'b1);
    cycle();

    // Two dispatches, both finished next cycle, commit together
    set_dp(0, 32'h100, 5'd3, 1'b1);
    set_dp(1, 32'h104, 5'd7, 1'b1);
    cycle();
    idle_inputs();
    set_ex(0, 0); set_ex(1, 1);
    cycle();
    idle_inputs();
    #1;
    chk("t2_comnum", bus.comnum_o, 2'd2);
    chk("t2_arfwe", bus.arfwe_o, 2'b11);
    chk("t2_dst", bus.dst_arf_o, {5'd7, 5'd3});
    chk("t2_pc", bus.commit_pc_o, {32'h104, 32'h100});
    cycle();
    #1 chk("t2_ptr", bus.commit_ptr_o, 6'd2);

    // Younger finishes first: nothing commits until the older one finishes
    set_dp(0, 32'h108, 5'd1, 1'b1);
    set_dp(1, 32'h10c, 5'd2, 1'b0);
    cycle();
    idle_inputs(); set_ex(2, 3);
    cycle();
    idle_inputs();
    #1 chk("t3_blocked", bus.comnum_o, 2'd0);
    set_ex(3, 2);
    cycle();
    idle_inputs();
    #1 chk("t3_comnum", bus.comnum_o, 2'd2);
    chk("t3_arfwe", bus.arfwe_o, 2'b01);
    cycle();

    // Fill to full, extra dispatch ignored, then drain through the wrap
    for (int i = 0; i < 32; i++) begin
      idle_inputs();
      set_dp(0, $urandom, 5'($urandom), 1'($urandom));
      set_dp(1, $urandom, 5'($urandom), 1'($urandom));
      cycle();
    end
    idle_inputs();
    #1 chk("t4_full", bus.full_o, 1'b1);
    chk("t4_ready", bus.dp_ready_o, 1'b0);
    set_dp(0, 32'hdead, 5'd9, 1'b1);
    set_dp(1, 32'hbeef, 5'd9, 1'b1);
    cycle();
    idle_inputs();
    #1 chk("t4_still_full", bus.full_o, 1'b1);
    chk("t4_ptr", bus.commit_ptr_o, 6'd4);
    seen_commits = 0;
    for (int c = 0; c < 16; c++) begin
      idle_inputs();
      for (int p = 0; p < EXP; p++) set_ex(p, (4 + 4*c + p) % N);
      cycle();
    end
    drain(100);
    chk("t4_commits", seen_commits, 64);
    chk("t4_wrap_ptr", bus.commit_ptr_o, 6'd4);

    // Completion to an unallocated entry is dropped
    idle_inputs(); set_ex(0, 10);
    cycle();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      set_dp(0, 32'h400 + 32'(8*i), 5'd4, 1'b1);
      set_dp(1, 32'h404 + 32'(8*i), 5'd5, 1'b1);
      cycle();
    end
    idle_inputs();
    #1 chk("t5_nocommit", bus.comnum_o, 2'd0);
    for (int p = 0; p < EXP; p++) set_ex(p, 4 + p);
    cycle();
    idle_inputs(); set_ex(0, 8); set_ex(1, 9);
    cycle();
    idle_inputs();
    for (int i = 0; i < 5; i++) cycle();
    #1 chk("t5_stuck_ptr", bus.commit_ptr_o, 6'd10);
    set_ex(0, 10); set_ex(1, 11);
    cycle();
    drain(10);
    chk("t5_ptr", bus.commit_ptr_o, 6'd12);

`ifdef ROB_EXCEPTION_EN
    // Exception at head: retire alone, then flush everything
    reset_i = 1'b0; idle_inputs(); cycle(); reset_i = 1'b1;
    set_dp(0, 32'h200, 5'd1, 1'b1);
    set_dp(1, 32'h204, 5'd2, 1'b1);
    cycle();
    idle_inputs(); set_ex(0, 0); set_ex(1, 1); bus.ex_exc_i[0] = 1'b1;
    cycle();
    idle_inputs();
    #1 chk("t6_exc", bus.exc_o, 1'b1);
    chk("t6_exc_pc", bus.exc_pc_o, 32'h200);
    chk("t6_arfwe", bus.arfwe_o, 2'b00);
    cycle();
    #1 chk("t6_empty", bus.empty_o, 1'b1);
    chk("t6_ptr", bus.commit_ptr_o, 6'd0);
    cycle();
`endif

    // Randomized traffic in phases of differing dispatch/completion pressure
    for (int c = 0; c < 4000; c++) begin
      mode = (c / 250) % 4;
      dpp = (mode == 0) ? 90 : (mode == 1) ? 60 : (mode == 2) ? 50 : 20;
      cpp = (mode == 0) ? 10 : (mode == 1) ? 50 : (mode == 2) ? 90 : 30;
      idle_inputs();
      if ($urandom % 100 < dpp) begin
        nv = $urandom_range(1, DP);
        for (int k = 0; k < nv; k++) set_dp(k, $urandom, 5'($urandom), 1'($urandom));
      end
      sz = mq.size();
      for (int p = 0; p < EXP; p++) begin
        if ($urandom % 100 < cpp) begin
          if (sz > 0 && ($urandom % 4) != 0) set_ex(p, mq[$urandom % sz].idx);
          else set_ex(p, $urandom % N);
`ifdef ROB_EXCEPTION_EN
          bus.ex_exc_i[p] = (($urandom % 20) == 0);
`endif
        end
      end
      reset_i = (($urandom % 600) != 0);
      cycle();
    end
    reset_i = 1'b1;
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
Parametrised reorder buffer, successor to the single-commit ROB. Owns head and tail pointers, accepts up to DP_WIDTH in-order dispatches per cycle, and takes completion writes from EX_PORTS execution units. Retires up to COMMIT_WIDTH consecutive finished entries per cycle to the ARF. Sits between the dispatch stage, the execution units and the architectural register file.

Parameters:
ROB_SEL, 6, entry index width; depth ROB_NUM = 2**ROB_SEL
DP_WIDTH, 2, dispatch slots per cycle (1..4)
COMMIT_WIDTH, 2, commit slots per cycle (1..4)
EX_PORTS, 4, completion ports
PC_LEN, 32, PC width
REG_SEL, 5, logical register index width

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous, active-low reset
dp_valid_i  in  DP_WIDTH  dispatch request per slot; must be contiguous from bit 0
dp_pc_i  in  DP_WIDTH*PC_LEN  PC per slot
dp_dstvalid_i  in  DP_WIDTH  slot writes a destination
dp_dst_i  in  DP_WIDTH*REG_SEL  logical destination per slot
dp_ready_o  out  1  free entries >= DP_WIDTH
dp_addr_o  out  DP_WIDTH*ROB_SEL  tail+k, the entry index for each slot (combinational)
ex_finish_i  in  EX_PORTS  completion strobe per port
ex_addr_i  in  EX_PORTS*ROB_SEL  completing entry per port
commit_ptr_o  out  ROB_SEL  head pointer
comnum_o  out  $clog2(COMMIT_WIDTH+1)  entries committing this cycle
arfwe_o  out  COMMIT_WIDTH  ARF write enable per commit slot
dst_arf_o  out  COMMIT_WIDTH*REG_SEL  destination per commit slot
commit_pc_o  out  COMMIT_WIDTH*PC_LEN  PC per commit slot
empty_o  out  1  count == 0
full_o  out  1  count == ROB_NUM

Behaviour:
- Reset (reset_i==0 at edge): head=tail=0, count=0, valid/finish cleared. Outputs: commit_ptr_o=0, comnum_o=0, arfwe_o=0, empty_o=1, full_o=0, dp_ready_o=1. Reset asserted mid-operation discards all entries. Payload arrays are not reset.
- Dispatch: dispatch is accepted only when dp_ready_o=1; dp_valid_i while not ready is ignored. ndp = popcount(dp_valid_i). Slot k writes entry (tail+k) mod ROB_NUM: valid=1, finish=0, pc, dst, dstvalid. tail += ndp on the edge.
- Completion: for each port p with ex_finish_i[p] and valid[ex_addr_i[p]], set finish. A strobe to an invalid entry is ignored. Duplicate addresses across ports are harmless.
- Commit is combinational on current state. Slot j is ready when entry head+j is valid & finish and all slots below j are ready, with j < count. comnum_o = number of ready slots. arfwe_o[j] = ready_j & dstvalid. On the edge, the committed entries' valid is cleared and head += comnum_o.
- Pointer arithmetic is mod ROB_NUM (natural ROB_SEL-bit wrap). count is ROB_SEL+1 bits; next count = count + ndp - comnum.
- Simultaneous events:
  - Dispatch and commit in the same cycle are both applied. Freed entries become visible to dp_ready_o in the next cycle only.
  - A completion targeting an entry committing this cycle has no effect.
  - A completion arriving the same cycle as an entry's allocation is ignored, since the entry is invalid before the edge.
- Full: dp_ready_o=0 and no allocation. Empty: comnum_o=0.

Optional Feature:
ROB_EXCEPTION_EN.
- When defined:
  - Adds input ex_exc_i[EX_PORTS], stored per entry together with finish.
  - Adds outputs exc_o (1 bit) and exc_pc_o (PC_LEN).
  - Commit stops before the first excepting entry. When that entry is at head, it retires with arfwe=0, and exc_o=1 with exc_pc_o = its PC for that one cycle.
  - On the following edge all entries are flushed: head=tail=0, count=0.
- When undefined: no exception ports or state, and commit is as above.

Decomposition:
- Shared package/header holds ROB_SEL, REG_SEL, PC_LEN defaults and ROB_NUM derivation, next to the existing consts.
- Sub-module rob_commit_sel: combinational prefix-ready chain producing the per-slot ready vector and comnum. It is reused by a future multi-retire LSQ.

Test Plan:
1. Reset then idle -> empty_o=1, comnum_o=0, commit_ptr_o=0, dp_ready_o=1.
2. Dispatch 2 (dst 3 and 7, both dstvalid), finish both on ports 0/1 next cycle -> following cycle comnum_o=2, arfwe_o=2'b11, dst_arf_o={7,3}; commit_ptr_o=2 afterwards.
3. Dispatch 2, finish only entry 1 -> comnum_o=0. Then finish entry 0 -> comnum_o=2 in that later cycle.
4. Fill 64 entries (32 cycles of 2) -> full_o=1, dp_ready_o=0, extra dp_valid_i ignored. Finish/commit all -> head wraps 63→0 and 64 commits are observed.
5. Completion to an unallocated entry 10, then dispatch into 10 -> finish[10]=0, no commit.
6. With ROB_EXCEPTION_EN: entry 0 finishes with exception, entry 1 finishes clean -> exc_o=1, exc_pc_o=PC0, arfwe_o=0. Next cycle empty_o=1 and entry 1 is never committed.
